// File: rtl/alu_acc_sequencer.sv
// Micro-sequencer for the 16-bit ALU+accumulator datapath: takes one command per
// valid/ready handshake and expands it into single-cycle ALU control words.
module alu_acc_sequencer #(
  parameter int unsigned W       = 16,
  parameter int unsigned K_WIDTH = 8,
  parameter logic [9:0]  CW_HOLD = 10'h000,
  parameter logic [9:0]  CW_LOAD = 10'h001,
  parameter logic [9:0]  CW_ADD  = 10'h002,
  parameter logic [9:0]  CW_SUB  = 10'h004,
  parameter logic [9:0]  CW_SHL  = 10'h040,
  parameter logic [9:0]  CW_SHR  = 10'h080
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [W-1:0]       cmd_operand,
  input  logic [3:0]         cmd_count,
  input  logic [K_WIDTH-1:0] cmd_k,
  output logic [9:0]         ctrl_word,
  output logic [W-1:0]       br_out,
  input  logic [3:0]         flags_in,
  output logic               done,
  output logic [3:0]         flags_out,
  output logic               cmd_err
);

  localparam int unsigned BitW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StExec  = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StClr   = 3'd3;
  localparam logic [2:0] StMshl  = 3'd4;
  localparam logic [2:0] StMadd  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [W-1:0]       operand_q, operand_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [3:0]         flags_q, flags_d;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    bit_d     = bit_q;
    flags_d   = flags_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          operand_d = cmd_operand;
          cnt_d     = cmd_count;
          k_d       = cmd_k;
          bit_d     = BitW'(K_WIDTH - 1);
          case (cmd_op)
            3'd1, 3'd2, 3'd3: state_d = StExec;
            3'd4, 3'd5:       state_d = (cmd_count == 4'd0) ? StDone : StShift;
            3'd6:             state_d = StClr;
            default:          state_d = StDone;  // NOP and reserved op: no ALU cycle
          endcase
        end
      end
      StExec: state_d = StDone;
      StShift: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      StClr:  state_d = StMshl;
      StMshl: state_d = StMadd;
      StMadd: begin
        if (bit_q == '0) begin
          state_d = StDone;
        end else begin
          bit_d   = bit_q - BitW'(1);
          state_d = StMshl;
        end
      end
      StDone: begin
        flags_d = flags_in;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      bit_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      bit_q     <= bit_d;
      flags_q   <= flags_d;
    end
  end

  // Moore decode: the word driven here lands in ACC at the closing edge.
  always_comb begin
    ctrl_word = CW_HOLD;
    br_out    = '0;
    case (state_q)
      StExec: begin
        br_out = operand_q;
        case (op_q)
          3'd1:    ctrl_word = CW_LOAD;
          3'd2:    ctrl_word = CW_ADD;
          3'd3:    ctrl_word = CW_SUB;
          default: ctrl_word = CW_HOLD;
        endcase
      end
      StShift: ctrl_word = (op_q == 3'd4) ? CW_SHL : CW_SHR;
      StClr:   ctrl_word = CW_LOAD;
      StMshl:  ctrl_word = CW_SHL;
      StMadd: begin
        if (k_q[bit_q]) begin
          ctrl_word = CW_ADD;
          br_out    = operand_q;
        end
      end
      default: ctrl_word = CW_HOLD;
    endcase
  end

  assign cmd_ready = (state_q == StIdle);
  assign done      = (state_q == StDone);
  assign cmd_err   = (state_q == StDone) && (op_q == 3'd7);
  assign flags_out = flags_q;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer: a behavioural accumulator datapath closes the loop so
// command results, latencies and captured flags can be checked against hand values.
module tb_alu_acc_sequencer;

  localparam logic [9:0] CW_HOLD = 10'h000;
  localparam logic [9:0] CW_LOAD = 10'h001;
  localparam logic [9:0] CW_ADD  = 10'h002;
  localparam logic [9:0] CW_SUB  = 10'h004;
  localparam logic [9:0] CW_SHL  = 10'h040;
  localparam logic [9:0] CW_SHR  = 10'h080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [15:0] cmd_operand = '0;
  logic [3:0]  cmd_count = '0;
  logic [7:0]  cmd_k = '0;
  logic [9:0]  ctrl_word;
  logic [15:0] br_out;
  logic        done;
  logic [3:0]  flags_out;
  logic        cmd_err;

  logic [15:0] dp_acc;
  logic [3:0]  dp_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_acc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_operand(cmd_operand),
    .cmd_count  (cmd_count),
    .cmd_k      (cmd_k),
    .ctrl_word  (ctrl_word),
    .br_out     (br_out),
    .flags_in   (dp_flags),
    .done       (done),
    .flags_out  (flags_out),
    .cmd_err    (cmd_err)
  );

  // Flags are {ZF,CF,OF,SF}; HOLD (or any unknown word) keeps ACC and flags.
  function automatic logic [19:0] dp_next(input logic [9:0] cw, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] f);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, o;
    case (cw)
      CW_LOAD: begin r = b; c = 1'b0; o = 1'b0; end
      CW_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      CW_SUB: begin
        s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
        o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      CW_SHL: begin r = {a[14:0], 1'b0}; c = a[15]; o = 1'b0; end
      CW_SHR: begin r = {1'b0, a[15:1]}; c = a[0]; o = 1'b0; end
      default: return {f, a};
    endcase
    return {(r == 16'h0), c, o, r[15], r};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_acc   <= '0;
      dp_flags <= '0;
    end else begin
      {dp_flags, dp_acc} <= dp_next(ctrl_word, dp_acc, br_out, dp_flags);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called and returns at a negedge with the sequencer idle.
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] opnd, input logic [3:0] cnt,
                         input logic [7:0] k, output int lat, output int adds);
    bit seen;
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_operand = opnd; cmd_count = cnt; cmd_k = k;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_operand = 16'hDEAD; cmd_count = 4'hF; cmd_k = 8'h00;
    lat = 0; adds = 0; seen = 0;
    while (!seen && lat < 64) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1;
      end else begin
        if (ctrl_word == CW_ADD) begin
          adds++;
          check("br_out_on_add", br_out, opnd);
        end
        check("ready_low_busy", cmd_ready, 0);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    check("done_ctrl_hold", ctrl_word, CW_HOLD);
    check("done_ready_low", cmd_ready, 0);
    check("done_cmd_err", cmd_err, (op == 3'd7));
    @(negedge clk);
    check("flags_captured", flags_out, dp_flags);
    check("idle_done_low", done, 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] opnd;
    logic [3:0]  cnt;
    logic [7:0]  k;
    logic [15:0] acc;
    int          lat;
    int          adds;
    logic        zf;
  } vec_t;

  vec_t v[12];

  initial begin
    int lat, adds;
    logic [15:0] acc0;

    v[0]  = '{3'd1, 16'h1234, 4'd0,  8'h00, 16'h1234, 2,  0, 1'b0};
    v[1]  = '{3'd2, 16'h0001, 4'd0,  8'h00, 16'h1235, 2,  1, 1'b0};
    v[2]  = '{3'd1, 16'h0003, 4'd0,  8'h00, 16'h0003, 2,  0, 1'b0};
    v[3]  = '{3'd4, 16'h0000, 4'd4,  8'h00, 16'h0030, 5,  0, 1'b0};
    v[4]  = '{3'd4, 16'h0000, 4'd0,  8'h00, 16'h0030, 1,  0, 1'b0};
    v[5]  = '{3'd5, 16'h0000, 4'd3,  8'h00, 16'h0006, 4,  0, 1'b0};
    // 0x0123 * 0xA5 = 291 * 165 = 48015 = 0xBB8F; k has four set bits
    v[6]  = '{3'd6, 16'h0123, 4'd0,  8'hA5, 16'hBB8F, 18, 4, 1'b0};
    v[7]  = '{3'd6, 16'hFFFF, 4'd0,  8'hFF, 16'hFF01, 18, 8, 1'b0};
    v[8]  = '{3'd3, 16'hFF01, 4'd0,  8'h00, 16'h0000, 2,  0, 1'b1};
    v[9]  = '{3'd0, 16'h5555, 4'd0,  8'h00, 16'h0000, 1,  0, 1'b1};
    v[10] = '{3'd1, 16'h0001, 4'd0,  8'h00, 16'h0001, 2,  0, 1'b0};
    v[11] = '{3'd4, 16'h0000, 4'd15, 8'h00, 16'h8000, 16, 0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl_word", ctrl_word, CW_HOLD);
    check("rst_br_out", br_out, 0);
    check("rst_done", done, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_flags_out", flags_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);

    for (int i = 0; i < 12; i++) begin
      run_cmd(v[i].op, v[i].opnd, v[i].cnt, v[i].k, lat, adds);
      check($sformatf("v%0d_acc", i), dp_acc, v[i].acc);
      check($sformatf("v%0d_latency", i), lat, v[i].lat);
      check($sformatf("v%0d_add_cycles", i), adds, v[i].adds);
      check($sformatf("v%0d_zf", i), flags_out[3], v[i].zf);
    end

    // Reserved op with cmd_valid held: two transfers, each separated by an IDLE cycle
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_operand = 16'h4444;
    acc0 = dp_acc;
    @(negedge clk);
    check("op7_done", done, 1);
    check("op7_err", cmd_err, 1);
    check("op7_ready_low", cmd_ready, 0);
    check("op7_ctrl_hold", ctrl_word, CW_HOLD);
    @(negedge clk);
    check("op7_idle_done", done, 0);
    check("op7_idle_err", cmd_err, 0);
    check("op7_idle_ready", cmd_ready, 1);
    @(negedge clk);
    check("op7_second_done", done, 1);
    check("op7_second_err", cmd_err, 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("op7_acc_kept", dp_acc, acc0);

    // Back-to-back ADDs with cmd_valid held
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_operand = 16'h0001;
    acc0 = dp_acc;
    @(negedge clk);
    check("b2b_exec_ctrl", ctrl_word, CW_ADD);
    check("b2b_exec_br", br_out, 16'h0001);
    check("b2b_exec_ready", cmd_ready, 0);
    @(negedge clk);
    check("b2b_done", done, 1);
    check("b2b_done_ready", cmd_ready, 0);
    @(negedge clk);
    check("b2b_idle_ready", cmd_ready, 1);
    check("b2b_idle_ctrl", ctrl_word, CW_HOLD);
    @(negedge clk);
    check("b2b_exec2_ctrl", ctrl_word, CW_ADD);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_done2", done, 1);
    @(negedge clk);
    check("b2b_acc", dp_acc, acc0 + 16'd2);
    check("b2b_no_third", ctrl_word, CW_HOLD);

    // Reset asserted in the middle of a multiply
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_operand = 16'h0123; cmd_k = 8'hA5;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mul_midway_busy", cmd_ready, 0);
    check("flags_nonzero_pre_rst", (flags_out != 4'h0), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", ctrl_word, CW_HOLD);
    check("midrst_br", br_out, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_flags", flags_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check("postrst_no_done", done, 0);
      check("postrst_ctrl_hold", ctrl_word, CW_HOLD);
    end
    run_cmd(3'd1, 16'h00AB, 4'd0, 8'h00, lat, adds);
    check("postrst_load_acc", dp_acc, 16'h00AB);
    check("postrst_load_lat", lat, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
